// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: a circular FIFO of pending
// stores that drain only in cycles without a load, with store-to-load forwarding.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         stValid,
    input  logic [ADDR_WIDTH-1:0]        stAddr,
    input  logic [DATA_WIDTH-1:0]        stData,
    output logic                         stReady,
    input  logic                         ldEn,
    input  logic [ADDR_WIDTH-1:0]        ldAddr,
    output logic                         fwdHit,
    output logic [DATA_WIDTH-1:0]        fwdData,
    output logic                         memWriteEn,
    output logic [ADDR_WIDTH-1:0]        memAddr,
    output logic [DATA_WIDTH-1:0]        memWriteData,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      head_d;
    logic [PTR_W-1:0]      tail_q;
    logic [PTR_W-1:0]      tail_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [PTR_W-1:0]      fwd_idx;
    logic                  push;
    logic                  drain;

    assign stReady = (count_q != CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push    = stValid && stReady;
    // Loads own the shared memory port; drain only in load-free cycles.
    assign drain   = !empty && !ldEn;

    always_comb begin
        memWriteEn   = drain;
        memAddr      = ldAddr;
        memWriteData = '0;
        if (drain) begin
            memAddr      = addr_q[head_q];
            memWriteData = data_q[head_q];
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        fwd_idx = head_q;
        if (ldEn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = head_q + PTR_W'(i);
                if (valid_q[fwd_idx] && (addr_q[fwd_idx] == ldAddr)) begin
                    fwdHit  = 1'b1;
                    fwdData = data_q[fwd_idx];
                end
            end
        end
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            addr_d[tail_q]  = stAddr;
            data_d[tail_q]  = stData;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (drain && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
